// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG word collector: von Neumann
// corrector states and pair-decode values.
package trng_pkg;

    localparam int unsigned WORD_WIDTH_DEF = 32;

    typedef enum logic [0:0] {
        VN_IDLE       = 1'b0,
        VN_HAVE_FIRST = 1'b1
    } vn_state_e;

    localparam logic [1:0] VN_PAIR_01 = 2'b01;
    localparam logic [1:0] VN_PAIR_10 = 2'b10;

    // A pair produces an output bit only when its two samples differ.
    function automatic logic vn_pair_emits(input logic [1:0] pair);
        logic res;
        case (pair)
            VN_PAIR_01: res = 1'b1;
            VN_PAIR_10: res = 1'b1;
            default:    res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/trng_sync_fifo.sv
// Generic show-ahead synchronous FIFO; the head word is held in a register
// and reads as zero whenever the FIFO is empty.
module trng_sync_fifo
    import trng_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_WIDTH_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             do_push_s, do_pop_s;

    // Next pointers, level and head word; a push into a slot that becomes
    // the head this cycle bypasses the memory.
    always_comb begin
        do_pop_s  = pop_i && (level_q != LVL_W'(0));
        do_push_s = push_i && ((level_q != LVL_W'(DEPTH)) || do_pop_s);
        rd_ptr_d  = do_pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (level_d == LVL_W'(0)) begin
            head_d = '0;
        end else if (do_push_s && (rd_ptr_d == wr_ptr_q)) begin
            head_d = wdata_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        valid_d = (level_d != LVL_W'(0));
        full_d  = (level_d == LVL_W'(DEPTH));
    end

    // Storage array and pointer/status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    assign rdata_o = head_q;
    assign full_o  = full_q;
    assign empty_o = ~valid_q;
    assign valid_o = valid_q;
    assign level_o = level_q;

endmodule

// File: rtl/trng_word_collector.sv
// Collects raw TRNG samples, optionally von Neumann debiases them, runs a
// repetition-count health test and packs accepted bits into buffered words.
module trng_word_collector
    import trng_pkg::*;
#(
    parameter int unsigned WORD_WIDTH    = WORD_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned RCT_CUTOFF    = 32,
    parameter int unsigned RCT_CNT_WIDTH = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en_i,
    input  logic                            debias_en_i,
    input  logic                            raw_bit_i,
    input  logic                            raw_valid_i,
    input  logic                            rd_i,
    input  logic                            clr_fail_i,
    output logic [WORD_WIDTH-1:0]           rdata_o,
    output logic                            rdata_valid_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o,
    output logic                            health_fail_o
);

    localparam int unsigned CNT_W = $clog2(WORD_WIDTH + 1);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

    vn_state_e                vn_q, vn_d;
    logic                     first_q, first_d;
    logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0]    shift_q, shift_d;
    logic                     pend_q, pend_d;
    logic [WORD_WIDTH-1:0]    pend_word_q, pend_word_d;
    logic [RCT_CNT_WIDTH-1:0] rct_cnt_q, rct_cnt_d, rct_next_s;
    logic                     last_bit_q, last_bit_d;
    logic                     fail_q, fail_d;

    logic                     rct_sample_s, trip_s, accept_s;
    logic                     emit_s, ebit_s;
    logic [WORD_WIDTH-1:0]    word_s, push_word_s;
    logic                     push_s, fifo_ready_s;
    logic                     fifo_full_s, fifo_empty_s, fifo_valid_s;
    logic [LVL_W-1:0]         fifo_level_s;

    // Repetition-count health test on every raw sample seen while enabled.
    always_comb begin
        rct_sample_s = en_i && raw_valid_i;
        if ((rct_cnt_q == RCT_CNT_WIDTH'(0)) || (raw_bit_i != last_bit_q)) begin
            rct_next_s = RCT_CNT_WIDTH'(1);
        end else if (rct_cnt_q != {RCT_CNT_WIDTH{1'b1}}) begin
            rct_next_s = rct_cnt_q + RCT_CNT_WIDTH'(1);
        end else begin
            rct_next_s = rct_cnt_q;
        end
        trip_s = rct_sample_s && (rct_next_s == RCT_CNT_WIDTH'(RCT_CUTOFF))
                 && (rct_cnt_q != RCT_CNT_WIDTH'(RCT_CUTOFF));

        if (!en_i) begin
            rct_cnt_d  = '0;
            last_bit_d = last_bit_q;
        end else if (rct_sample_s) begin
            rct_cnt_d  = rct_next_s;
            last_bit_d = raw_bit_i;
        end else begin
            rct_cnt_d  = rct_cnt_q;
            last_bit_d = last_bit_q;
        end

        // A trip in the same cycle as a clear keeps the failure flag set.
        if (trip_s) begin
            fail_d = 1'b1;
        end else if (clr_fail_i) begin
            fail_d    = 1'b0;
            rct_cnt_d = '0;
        end else begin
            fail_d = fail_q;
        end
    end

    // Sample acceptance and von Neumann pair decoding.
    always_comb begin
        accept_s = en_i && raw_valid_i && !pend_q && !fail_q;
        emit_s   = 1'b0;
        ebit_s   = 1'b0;
        vn_d     = vn_q;
        first_d  = first_q;
        if (accept_s) begin
            if (debias_en_i) begin
                case (vn_q)
                    VN_IDLE: begin
                        first_d = raw_bit_i;
                        vn_d    = VN_HAVE_FIRST;
                    end
                    VN_HAVE_FIRST: begin
                        vn_d   = VN_IDLE;
                        emit_s = vn_pair_emits({first_q, raw_bit_i});
                        ebit_s = first_q;
                    end
                    default: vn_d = VN_IDLE;
                endcase
            end else begin
                emit_s = 1'b1;
                ebit_s = raw_bit_i;
                vn_d   = VN_IDLE;
            end
        end else begin
            vn_d = debias_en_i ? vn_q : VN_IDLE;
        end
        if (!en_i || trip_s) begin
            vn_d = VN_IDLE;
        end else begin
            vn_d = vn_d;
        end
    end

    // Packer: shifts emitted bits in, completes words and routes them to the
    // FIFO or the single pending slot when the FIFO has no room.
    always_comb begin
        fifo_ready_s = !fifo_full_s || (rd_i && !fifo_empty_s);
        word_s       = {shift_q[WORD_WIDTH-2:0], ebit_s};
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        pend_d       = pend_q;
        pend_word_d  = pend_word_q;
        push_s       = 1'b0;
        push_word_s  = pend_word_q;

        if (pend_q && fifo_ready_s && !fail_q && !trip_s) begin
            push_s = 1'b1;
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        if (emit_s && !trip_s) begin
            if (bit_cnt_q == CNT_W'(WORD_WIDTH - 1)) begin
                shift_d   = '0;
                bit_cnt_d = '0;
                if (fifo_ready_s) begin
                    push_s      = 1'b1;
                    push_word_s = word_s;
                end else begin
                    pend_d      = 1'b1;
                    pend_word_d = word_s;
                end
            end else begin
                shift_d   = word_s;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end else begin
            shift_d = shift_q;
        end

        if (!en_i || trip_s) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else begin
            bit_cnt_d = bit_cnt_d;
        end
    end

    // Collector state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vn_q        <= VN_IDLE;
            first_q     <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            pend_q      <= 1'b0;
            pend_word_q <= '0;
            rct_cnt_q   <= '0;
            last_bit_q  <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            vn_q        <= vn_d;
            first_q     <= first_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            pend_q      <= pend_d;
            pend_word_q <= pend_word_d;
            rct_cnt_q   <= rct_cnt_d;
            last_bit_q  <= last_bit_d;
            fail_q      <= fail_d;
        end
    end

    trng_sync_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (rd_i),
        .wdata_i (push_word_s),
        .rdata_o (rdata_o),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .valid_o (fifo_valid_s),
        .level_o (fifo_level_s)
    );

    assign rdata_valid_o = fifo_valid_s;
    assign fifo_level_o  = fifo_level_s;
    assign health_fail_o = fail_q;

endmodule

// File: tb/tb_trng_word_collector.sv
// Directed self-checking bench for trng_word_collector.
module tb_trng_word_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_i, debias_en_i, raw_bit_i, raw_valid_i, rd_i, clr_fail_i;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic [2:0]  fifo_level_o;
    logic        health_fail_o;

    int n_cmp = 0;
    int n_err = 0;

    trng_word_collector dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_i),
        .debias_en_i   (debias_en_i),
        .raw_bit_i     (raw_bit_i),
        .raw_valid_i   (raw_valid_i),
        .rd_i          (rd_i),
        .clr_fail_i    (clr_fail_i),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .fifo_level_o  (fifo_level_o),
        .health_fail_o (health_fail_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] data,
                             input logic valid, input logic [2:0] lvl, input logic fail);
        check({tag, ".rdata"}, rdata_o, data);
        check({tag, ".valid"}, 32'(rdata_valid_o), 32'(valid));
        check({tag, ".level"}, 32'(fifo_level_o), 32'(lvl));
        check({tag, ".fail"}, 32'(health_fail_o), 32'(fail));
    endtask

    task automatic send_bit(input logic b);
        raw_bit_i   = b;
        raw_valid_i = 1'b1;
        @(posedge clk);
        #1;
        raw_valid_i = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    task automatic pop;
        rd_i = 1'b1;
        @(posedge clk);
        #1;
        rd_i = 1'b0;
    endtask

    task automatic idle_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] words [5];
        words[0] = 32'h12345678;
        words[1] = 32'h9ABCDEF0;
        words[2] = 32'h0F1E2D3C;
        words[3] = 32'hC3B4A596;
        words[4] = 32'h6D5B3A29;

        rst = 1'b1; en_i = 1'b0; debias_en_i = 1'b0; raw_bit_i = 1'b0;
        raw_valid_i = 1'b0; rd_i = 1'b0; clr_fail_i = 1'b0;
        #22;
        check_out("reset", 32'h0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: raw passthrough packing, MSB first
        en_i = 1'b1;
        send_bits(32'hA5A50F0F, 32);
        check_out("pass.word", 32'hA5A50F0F, 1'b1, 3'd1, 1'b0);
        pop();
        check_out("pass.pop", 32'h0, 1'b0, 3'd0, 1'b0);
        pop();
        check_out("pass.pop_empty", 32'h0, 1'b0, 3'd0, 1'b0);

        // 2: von Neumann, pairs 01,10,00,11 x16 -> 0x55555555
        debias_en_i = 1'b1;
        for (int r = 0; r < 16; r++) begin
            send_bits(32'h63, 8);
        end
        check_out("vn.word", 32'h55555555, 1'b1, 3'd1, 1'b0);
        pop();
        check("vn.pop_level", 32'(fifo_level_o), 32'd0);
        debias_en_i = 1'b0;

        // 3: fill the FIFO, stall with a pending word, then drain in order
        for (int k = 0; k < 4; k++) begin
            send_bits(words[k], 32);
        end
        check_out("full.four", words[0], 1'b1, 3'd4, 1'b0);
        send_bits(words[4], 32);
        check_out("full.pending", words[0], 1'b1, 3'd4, 1'b0);
        send_bits(32'hB2, 8);
        check("full.ignored_level", 32'(fifo_level_o), 32'd4);
        pop();
        check_out("full.pop_push", words[1], 1'b1, 3'd4, 1'b0);
        pop();
        check_out("drain.w2", words[2], 1'b1, 3'd3, 1'b0);
        pop();
        check_out("drain.w3", words[3], 1'b1, 3'd2, 1'b0);
        pop();
        check_out("drain.w4", words[4], 1'b1, 3'd1, 1'b0);
        pop();
        check_out("drain.empty", 32'h0, 1'b0, 3'd0, 1'b0);

        // 4: repetition-count trip; a clear on the tripping edge loses
        send_bits(32'hFFFFFFFF, 31);
        check_out("rct.31", 32'h0, 1'b0, 3'd0, 1'b0);
        clr_fail_i = 1'b1;
        send_bit(1'b1);
        check_out("rct.trip", 32'h0, 1'b0, 3'd0, 1'b1);
        idle_cycle();
        clr_fail_i = 1'b0;
        check_out("rct.cleared", 32'h0, 1'b0, 3'd0, 1'b0);
        send_bits(32'h3C3CA5A5, 32);
        check_out("rct.after", 32'h3C3CA5A5, 1'b1, 3'd1, 1'b0);
        pop();

        // 5: asynchronous reset mid-word with two words buffered
        send_bits(words[0], 32);
        send_bits(words[1], 32);
        send_bits(32'h5555, 17);
        check("rst.pre_level", 32'(fifo_level_o), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check_out("rst.async", 32'h0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_bits(32'h0F0FF0F0, 32);
        check_out("rst.fresh", 32'h0F0FF0F0, 1'b1, 3'd1, 1'b0);
        pop();

        // 6: en_i drop discards the partial word
        send_bits(32'h2AB, 10);
        en_i = 1'b0;
        idle_cycle();
        idle_cycle();
        en_i = 1'b1;
        check("en.no_word", 32'(fifo_level_o), 32'd0);
        send_bits(32'hDEADBEEF, 32);
        check_out("en.word", 32'hDEADBEEF, 1'b1, 3'd1, 1'b0);
        pop();
        check("en.pop_level", 32'(fifo_level_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
